// File: rtl/vrf_loader_pkg.sv
// Shared definitions for the VRF loader: FSM state encoding and lane-width helper.
// VRF geometry normally comes from the existing MVU includes; fallbacks apply only when those are absent.
`ifndef VRF_DWIDTH
`define VRF_DWIDTH 128
`endif
`ifndef VRF_AWIDTH
`define VRF_AWIDTH 4
`endif

package vrf_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int unsigned lane_bits(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/vrf_row_packer.sv
// Packs IN_WIDTH beats into LANES-wide rows, first beat in the LSBs; a flush
// zero-pads the unused upper lanes and emits the partial row immediately.
module vrf_row_packer
   import vrf_loader_pkg::*;
#(
   parameter int unsigned IN_WIDTH = 32,
   parameter int unsigned LANES    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      beat_i,
   input  logic [IN_WIDTH-1:0]       data_i,
   input  logic                      flush_i,
   output logic                      row_full_o,
   output logic                      row_valid_o,
   output logic [LANES*IN_WIDTH-1:0] row_data_o
);

   localparam int unsigned LW = lane_bits(LANES);
   localparam int unsigned RW = LANES * IN_WIDTH;

   logic [LW-1:0] lane_q, lane_d;
   logic [RW-1:0] acc_q, acc_d, row_q, row_d, ins_s;
   logic          vld_q, vld_d;

   assign row_full_o  = (lane_q == LW'(LANES - 1));
   assign row_valid_o = vld_q;
   assign row_data_o  = row_q;

   // Insert the incoming beat; the accumulator is kept zeroed past the fill point, so padding is free.
   always_comb begin
      ins_s = acc_q;
      ins_s[lane_q*IN_WIDTH +: IN_WIDTH] = data_i;
      acc_d  = acc_q;
      lane_d = lane_q;
      row_d  = row_q;
      vld_d  = 1'b0;
      if (beat_i) begin
         if (row_full_o || flush_i) begin
            row_d  = ins_s;
            vld_d  = 1'b1;
            acc_d  = '0;
            lane_d = '0;
         end else begin
            acc_d  = ins_s;
            lane_d = lane_q + LW'(1);
         end
      end else begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q <= '0;
         acc_q  <= '0;
         row_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         lane_q <= lane_d;
         acc_q  <= acc_d;
         row_q  <= row_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: rtl/vrf_loader.sv
// Streams beats into MVU VRF rows starting at cfg_base, pulsing done when the block is loaded.
// Optional feature: define VRF_LOADER_AUTOSTART_EN to drive the MVU start pulse from here.
module vrf_loader
   import vrf_loader_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 32,
   parameter int unsigned VRF_DWIDTH = `VRF_DWIDTH,
   parameter int unsigned VRF_AWIDTH = `VRF_AWIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [VRF_AWIDTH-1:0] cfg_base,
   input  logic [VRF_AWIDTH:0]   cfg_rows,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_last,
   output logic                  vec_we,
   output logic [VRF_AWIDTH-1:0] vrf_wr_addr,
   output logic [VRF_DWIDTH-1:0] vec,
   output logic                  busy,
   output logic                  done,
   output logic                  short_load,
   output logic                  start
);

   localparam int unsigned LANES = VRF_DWIDTH / IN_WIDTH;

   state_e                state_q, state_d;
   logic [VRF_AWIDTH:0]   rows_q, rows_d;
   logic [VRF_AWIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
   logic                  short_q, short_d;
   logic                  beat_s, row_full_s;

   vrf_row_packer #(
      .IN_WIDTH (IN_WIDTH),
      .LANES    (LANES)
   ) u_packer (
      .clk         (clk),
      .rst         (rst),
      .beat_i      (beat_s),
      .data_i      (in_data),
      .flush_i     (in_last),
      .row_full_o  (row_full_s),
      .row_valid_o (vec_we),
      .row_data_o  (vec)
   );

   // rows_q==0 inside LOAD is the one-cycle drain that lines done up after the final write.
   always_comb begin
      state_d = state_q;
      rows_d  = rows_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      short_d = short_q;
      beat_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               rows_d  = cfg_rows;
               ptr_d   = cfg_base;
               short_d = 1'b0;
               state_d = (cfg_rows == '0) ? ST_DONE : ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (rows_q == '0) begin
               state_d = ST_DONE;
            end else if (in_valid) begin
               beat_s = 1'b1;
               if (row_full_s || in_last) begin
                  addr_d  = ptr_q;
                  ptr_d   = ptr_q + VRF_AWIDTH'(1);
                  rows_d  = in_last ? '0 : (rows_q - (VRF_AWIDTH+1)'(1));
                  short_d = in_last & ~((rows_q == (VRF_AWIDTH+1)'(1)) & row_full_s);
               end else begin
                  rows_d = rows_q;
               end
            end else begin
               beat_s = 1'b0;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rows_q  <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         short_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rows_q  <= rows_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         short_q <= short_d;
      end
   end

   assign cfg_ready   = (state_q == ST_IDLE);
   assign in_ready    = (state_q == ST_LOAD) && (rows_q != '0);
   assign busy        = (state_q == ST_LOAD) || (state_q == ST_DONE);
   assign done        = (state_q == ST_DONE);
   assign short_load  = short_q;
   assign vrf_wr_addr = addr_q;

`ifdef VRF_LOADER_AUTOSTART_EN
   logic zero_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
      end else if ((state_q == ST_IDLE) && cfg_valid) begin
         zero_q <= (cfg_rows == '0);
      end else begin
         zero_q <= zero_q;
      end
   end

   assign start = done & ~short_q & ~zero_q;
`else
   assign start = 1'b0;
`endif

endmodule

// File: tb/tb_vrf_loader.sv
// Directed bench for vrf_loader (IN_WIDTH=32, 4 lanes, 4-bit VRF address) with a row-level
// reference model and a per-cycle compare process.
module tb_vrf_loader;

   typedef struct {
      logic [3:0]   addr;
      logic [127:0] data;
   } wr_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cfg_valid = 1'b0;
   logic         cfg_ready;
   logic [3:0]   cfg_base = 4'd0;
   logic [4:0]   cfg_rows = 5'd0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_data = 32'd0;
   logic         in_last = 1'b0;
   logic         vec_we;
   logic [3:0]   vrf_wr_addr;
   logic [127:0] vec;
   logic         busy, done, short_load, start;

   int  n_chk = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  accept_cyc = 0;
   int  last_we_cyc = 0;
   int  we_cnt = 0;
   int  done_cnt = 0;
   logic [127:0] last_vec = 128'd0;
   wr_t exp_q[$];
   bit  exp_zero = 1'b0;
   bit  exp_short = 1'b0;
   bit  exp_start = 1'b0;

   vrf_loader #(
      .IN_WIDTH   (32),
      .VRF_DWIDTH (128),
      .VRF_AWIDTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_base    (cfg_base),
      .cfg_rows    (cfg_rows),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .vec_we      (vec_we),
      .vrf_wr_addr (vrf_wr_addr),
      .vec         (vec),
      .busy        (busy),
      .done        (done),
      .short_load  (short_load),
      .start       (start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
      n_chk++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, expv);
      end
   endtask

   // Model: rows are consecutive groups of 4 beats, the last group zero-padded; addresses wrap mod 16.
   task automatic model_push(input int base, input int rows, input int nb, input int seed);
      int nrows;
      wr_t w;
      nrows = (nb + 3) / 4;
      if (nrows > rows) nrows = rows;
      for (int r = 0; r < nrows; r++) begin
         w.addr = 4'((base + r) % 16);
         w.data = 128'd0;
         for (int k = 0; k < 4; k++) begin
            if (r * 4 + k < nb) w.data[k*32 +: 32] = 32'(seed + r * 4 + k);
         end
         exp_q.push_back(w);
      end
      exp_zero  = (rows == 0);
      exp_short = (nb < rows * 4);
`ifdef VRF_LOADER_AUTOSTART_EN
      exp_start = !exp_short && (rows != 0);
`else
      exp_start = 1'b0;
`endif
   endtask

   // Per-cycle compare against the model queue and done/start/short expectations.
   always @(negedge clk) begin
      wr_t e;
      cyc++;
      if (!rst) begin
         if (cfg_valid && cfg_ready) accept_cyc = cyc;
         chk("busy_vs_cfg_ready", 128'(busy), 128'(!cfg_ready));
         if (vec_we) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_vec_we: got addr %h vec %h expected no write", vrf_wr_addr, vec);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 128'(vrf_wr_addr), 128'(e.addr));
               chk("wr_vec", vec, e.data);
            end
            we_cnt++;
            last_we_cyc = cyc;
            last_vec = vec;
         end
         if (done) begin
            done_cnt++;
            if (exp_zero) chk("done_after_accept", 128'(cyc), 128'(accept_cyc + 1));
            else          chk("done_after_last_we", 128'(cyc), 128'(last_we_cyc + 1));
            chk("rows_outstanding_at_done", 128'(exp_q.size()), 128'd0);
            chk("short_load_at_done", 128'(short_load), 128'(exp_short));
            chk("start_at_done", 128'(start), 128'(exp_start));
         end else begin
            chk("start_without_done", 128'(start), 128'd0);
         end
      end
   end

   task automatic send_cmd(input int base, input int rows);
      int g;
      cfg_valid = 1'b1;
      cfg_base  = 4'(base);
      cfg_rows  = 5'(rows);
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!cfg_ready && g < 50);
      if (g >= 50) chk("cfg_ready_timeout", 128'(cfg_ready), 128'd1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic feed(input int nb, input int seed, input bit gaps, input bit mark_last);
      int g;
      for (int i = 0; i < nb; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data  = 32'(seed + i);
         in_last  = mark_last && (i == nb - 1);
         g = 0;
         do begin
            @(negedge clk);
            g++;
         end while (!in_ready && g < 50);
         if (g >= 50) chk("in_ready_timeout", 128'(in_ready), 128'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done();
      int d0;
      int g;
      d0 = done_cnt;
      g = 0;
      while (done_cnt == d0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (done_cnt == d0) chk("done_timeout", 128'(done_cnt), 128'(d0 + 1));
      @(posedge clk); #1;
   endtask

   task automatic run(input int base, input int rows, input int nb, input int seed, input bit gaps);
      model_push(base, rows, nb, seed);
      send_cmd(base, rows);
      feed(nb, seed, gaps, 1'b1);
      wait_done();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_vec_we"}, 128'(vec_we), 128'd0);
      chk({tag, "_addr"}, 128'(vrf_wr_addr), 128'd0);
      chk({tag, "_vec"}, vec, 128'd0);
      chk({tag, "_done"}, 128'(done), 128'd0);
      chk({tag, "_start"}, 128'(start), 128'd0);
      chk({tag, "_busy"}, 128'(busy), 128'd0);
      chk({tag, "_in_ready"}, 128'(in_ready), 128'd0);
      chk({tag, "_short"}, 128'(short_load), 128'd0);
   endtask

   initial begin
      int w0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("cfg_ready_after_reset", 128'(cfg_ready), 128'd1);
      @(posedge clk); #1;

      // Full-rate load: base 2, 3 rows, beats 0..11.
      w0 = we_cnt;
      model_push(2, 3, 12, 0);
      chk("model_row0_data", exp_q[0].data, 128'h00000003_00000002_00000001_00000000);
      chk("model_row0_addr", 128'(exp_q[0].addr), 128'd2);
      chk("model_row2_addr", 128'(exp_q[2].addr), 128'd4);
      send_cmd(2, 3);
      feed(12, 0, 1'b0, 1'b1);
      wait_done();
      chk("full_write_count", 128'(we_cnt - w0), 128'd3);
      chk("full_last_row", last_vec, 128'h0000000b_0000000a_00000009_00000008);

      // Address wrap: base 15, 2 rows.
      w0 = we_cnt;
      model_push(15, 2, 8, 32'h100);
      chk("model_wrap_addr0", 128'(exp_q[0].addr), 128'd15);
      chk("model_wrap_addr1", 128'(exp_q[1].addr), 128'd0);
      send_cmd(15, 2);
      feed(8, 32'h100, 1'b0, 1'b1);
      wait_done();
      chk("wrap_write_count", 128'(we_cnt - w0), 128'd2);
      chk("wrap_final_addr", 128'(vrf_wr_addr), 128'd0);

      // Short stream: 4 rows requested, 6 beats with in_last on the sixth.
      w0 = we_cnt;
      run(0, 4, 6, 0, 1'b0);
      chk("short_write_count", 128'(we_cnt - w0), 128'd2);
      chk("short_padded_row", last_vec, 128'h00000000_00000000_00000005_00000004);
      chk("short_load_sticky", 128'(short_load), 128'd1);

      // Zero rows: no writes, done right after accept, short flag cleared by the accept.
      w0 = we_cnt;
      run(5, 0, 0, 0, 1'b0);
      chk("zero_write_count", 128'(we_cnt - w0), 128'd0);
      chk("zero_short_cleared", 128'(short_load), 128'd0);

      // Stalled stream must reproduce the full-rate result.
      w0 = we_cnt;
      run(2, 3, 12, 0, 1'b1);
      chk("stall_write_count", 128'(we_cnt - w0), 128'd3);
      chk("stall_last_row", last_vec, 128'h0000000b_0000000a_00000009_00000008);

      // Reset after 5 beats: row 0 is written, the partial row 1 is discarded.
      model_push(7, 3, 4, 32'h40);
      send_cmd(7, 3);
      feed(5, 32'h40, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      w0 = we_cnt;
      repeat (20) @(negedge clk);
      chk("no_write_after_reset", 128'(we_cnt - w0), 128'd0);
      chk("reset_rows_consumed", 128'(exp_q.size()), 128'd0);
      chk("cfg_ready_after_midrst", 128'(cfg_ready), 128'd1);
      chk("in_ready_after_midrst", 128'(in_ready), 128'd0);
      chk("busy_after_midrst", 128'(busy), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
